seq_divider: RTL and testbench

Iterative restoring divider that undoes the shift-add multiplier's work: it takes a 2·WIDTH-bit dividend (a product) and a WIDTH-bit divisor, and returns quotient and remainder after a start/done handshake. It resolves one quotient bit per clock. It uses the same clk/rst/start/done control style as the multiplier top and sits beside it in the arithmetic datapath.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 30 +++
 rtl/seq_divider.sv | 138 +++++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
//  div_pkg : shared types and constants for the sequential restoring divider
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Sliced down to 2*WIDTH bits by the user; wide enough for WIDTH up to 32.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  div_step : one combinational restoring-division iteration
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   partial_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   partial_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // When the subtract is taken, shifted < 2*divisor, so WIDTH+1 bits hold the difference.
  always_comb begin
    shifted     = {partial_in, bit_in};
    q_bit       = (shifted >= {2'b00, divisor});
    diff        = shifted[WIDTH:0] - {1'b0, divisor};
    partial_out = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  seq_divider : iterative restoring divider, one quotient bit per clock
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int             CW   = $clog2(2*WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(2*WIDTH-1);

  state_t               state_q, state_d;
  logic                 start_q;
  logic [2*WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH:0]       partial_q, partial_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [WIDTH:0]       step_partial;
  logic                 step_q_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .partial_in  (partial_q),
    .bit_in      (dvd_q[2*WIDTH-1]),
    .divisor     (dsr_q),
    .partial_out (step_partial),
    .q_bit       (step_q_bit)
  );

  assign accept = start && !start_q && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    partial_d   = partial_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (divisor == '0) begin
            quotient_d  = DIV0_QUOTIENT[2*WIDTH-1:0];
            remainder_d = '0;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            dvd_d     = dividend;
            dsr_d     = divisor;
            partial_d = '0;
            cnt_d     = '0;
            dbz_d     = 1'b0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // The dividend register shifts out numerator bits and fills with quotient bits.
        dvd_d     = {dvd_q[2*WIDTH-2:0], step_q_bit};
        partial_d = step_partial;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quotient_d  = {dvd_q[2*WIDTH-2:0], step_q_bit};
          remainder_d = step_partial[WIDTH-1:0];
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      partial_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      partial_q   <= partial_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  tb_seq_divider : directed self-checking bench for seq_divider (WIDTH=8)
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; waits for done and checks latency and results.
  task automatic wait_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                             input logic ez, input int exp_lat);
    int lat;
    int nbusy;
    lat   = -1;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_busy_cycles"}, nbusy, (exp_lat == 0) ? 0 : 16);
    check_eq({tag, "_quotient"}, quotient, eq);
    check_eq({tag, "_remainder"}, remainder, er);
    check_eq({tag, "_dbz"}, div_by_zero, ez);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic ez,
                       input int exp_lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    wait_result(tag, eq, er, ez, exp_lat);
  endtask

  initial begin
    int ndone;

    #1;
    check_eq("rst_quotient", quotient, 16'h0);
    check_eq("rst_remainder", remainder, 8'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_dbz", div_by_zero, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_op("d2451_19",   16'h0993, 8'h13, 16'h0081, 8'd0,   1'b0, 16);
    do_op("d2460_19",   16'd2460, 8'd19, 16'd129,  8'd9,   1'b0, 16);
    do_op("dffff_ff",   16'hFFFF, 8'hFF, 16'h0101, 8'd0,   1'b0, 16);
    do_op("dffff_1",    16'hFFFF, 8'h01, 16'hFFFF, 8'd0,   1'b0, 16);
    do_op("d100_200",   16'd100,  8'd200, 16'd0,   8'd100, 1'b0, 16);
    do_op("div0",       16'h1234, 8'h00, 16'hFFFF, 8'd0,   1'b1, 0);
    do_op("after_div0", 16'd1000, 8'd7,  16'd142,  8'd6,   1'b0, 16);

    // Start held high for 60 cycles gives exactly one operation.
    @(negedge clk);
    dividend = 16'd2460;
    divisor  = 8'd19;
    start    = 1'b1;
    ndone    = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check_eq("held_done_count", ndone, 1);
    check_eq("held_quotient", quotient, 16'd129);
    check_eq("held_remainder", remainder, 8'd9);

    // New edge and operand changes during RUN are ignored.
    @(negedge clk);
    dividend = 16'd5000;
    divisor  = 8'd13;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 16'hFFFF;
    divisor  = 8'd3;
    ndone    = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check_eq("ignored_done_count", ndone, 1);
    check_eq("ignored_quotient", quotient, 16'd384);
    check_eq("ignored_remainder", remainder, 8'd8);

    // Reset around iteration 8 clears everything asynchronously, no done afterwards.
    @(negedge clk);
    dividend = 16'h0993;
    divisor  = 8'h13;
    start    = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_quotient", quotient, 16'h0);
    check_eq("midrst_remainder", remainder, 8'h0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check_eq("midrst_no_activity", ndone, 0);
    do_op("post_rst", 16'hFFFF, 8'hFF, 16'h0101, 8'd0, 1'b0, 16);

    // Start held high across reset release is accepted on the first edge after release.
    @(negedge clk);
    rst      = 1'b1;
    dividend = 16'd2460;
    divisor  = 8'd19;
    start    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    wait_result("start_thru_rst", 16'd129, 8'd9, 1'b0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
